// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and flag bundle shared by the alu_seq files
package alu_seq_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_NOR = 3'b011;
    localparam logic [2:0] ALU_OP_ADD = 3'b100;
    localparam logic [2:0] ALU_OP_SLL = 3'b101;
    localparam logic [2:0] ALU_OP_SRL = 3'b110;
    localparam logic [2:0] ALU_OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        HOLD  = 2'd3
    } alu_state_t;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
        logic less;
    } alu_flags_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
    endfunction

    // Flags for results that never carry signed-arithmetic meaning.
    function automatic alu_flags_t mk_flags(input logic cout, input logic zero,
                                            input logic negative);
        alu_flags_t f;
        f          = '0;
        f.cout     = cout;
        f.zero     = zero;
        f.negative = negative;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - combinational logic and add/sub datapath for the single-cycle ops
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_into_msb;

    always_comb begin
        b_eff          = sub ? ~b : b;
        sum            = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out without a second adder.
        carry_into_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];

        result = '0;
        flags  = '0;
        case (op)
            ALU_OP_AND: result = a & b;
            ALU_OP_OR:  result = a | b;
            ALU_OP_XOR: result = a ^ b;
            ALU_OP_NOR: result = ~(a | b);
            ALU_OP_ADD: begin
                result         = sum[WIDTH-1:0];
                flags.cout     = sum[WIDTH];
                flags.overflow = carry_into_msb ^ sum[WIDTH];
                flags.less     = sub & (sum[WIDTH-1] ^ (carry_into_msb ^ sum[WIDTH]));
            end
            default: ;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with bit-serial shifts; ALU_SEQ_MUL_EN adds shift-add multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             less,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_t       state, state_next;

    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;
    logic             illegal_q;
    logic [WIDTH-1:0] hold_result;
    alu_flags_t       hold_flags;

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             sh_left;
    logic             sh_arith;
    logic [WIDTH-1:0] sh_next;
    logic             sh_bit;

    logic [WIDTH-1:0] comb_result;
    alu_flags_t       comb_flags;

    logic             accept;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_result;
    alu_flags_t       fin_flags;
    logic             fin_illegal;
    logic             park;
    logic             start_shift;
    logic [SHAMT_W-1:0] shamt;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mc;
    logic [WIDTH-1:0]   mul_mp;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic               start_mul;
`endif

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (a),
        .b      (b),
        .op     (op),
        .sub    (sub),
        .result (comb_result),
        .flags  (comb_flags)
    );

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHAMT_W-1:0];

    assign sh_next = sh_left ? {shreg[WIDTH-2:0], 1'b0}
                             : {sh_arith & shreg[WIDTH-1], shreg[WIDTH-1:1]};
    assign sh_bit  = sh_left ? shreg[WIDTH-1] : shreg[0];

`ifdef ALU_SEQ_MUL_EN
    assign mul_acc_next = mul_mp[0] ? (mul_acc + mul_mc) : mul_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fin_valid   = 1'b0;
        fin_result  = '0;
        fin_flags   = '0;
        fin_illegal = 1'b0;
        start_shift = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        start_mul   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift_op(op)) begin
                        if (shamt == '0) begin
                            fin_valid  = 1'b1;
                            fin_result = a;
                            fin_flags  = mk_flags(1'b0, a == '0, a[WIDTH-1]);
                        end else begin
                            start_shift = 1'b1;
                            state_next  = SHIFT;
                        end
                    end else if (op == ALU_OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
                        start_mul  = 1'b1;
                        state_next = MUL;
`else
                        fin_valid   = 1'b1;
                        fin_illegal = 1'b1;
                        fin_flags   = mk_flags(1'b0, 1'b1, 1'b0);
`endif
                    end else begin
                        fin_valid  = 1'b1;
                        fin_result = comb_result;
                        fin_flags  = comb_flags;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    fin_valid  = 1'b1;
                    fin_result = sh_next;
                    fin_flags  = mk_flags(sh_bit, sh_next == '0, sh_next[WIDTH-1]);
                    state_next = IDLE;
                end
            end
            MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (cnt == CNT_W'(1)) begin
                    fin_valid  = 1'b1;
                    fin_result = mul_acc_next[WIDTH-1:0];
                    fin_flags  = mk_flags(|mul_acc_next[2*WIDTH-1:WIDTH],
                                          mul_acc_next[WIDTH-1:0] == '0,
                                          mul_acc_next[WIDTH-1]);
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A multi-cycle result finishing behind a stalled one is parked until the old one drains.
        park = fin_valid && (state != IDLE) && out_valid && !out_ready;
        if (park) begin
            state_next = HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            hold_result <= '0;
            hold_flags  <= '0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                result_q  <= hold_result;
                flags_q   <= hold_flags;
                illegal_q <= 1'b0;
            end
        end else if (park) begin
            hold_result <= fin_result;
            hold_flags  <= fin_flags;
        end else if (fin_valid) begin
            result_q  <= fin_result;
            flags_q   <= fin_flags;
            illegal_q <= fin_illegal;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            cnt      <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
        end else if (start_shift) begin
            shreg    <= a;
            cnt      <= CNT_W'(shamt);
            sh_left  <= (op == ALU_OP_SLL);
            sh_arith <= sub;
`ifdef ALU_SEQ_MUL_EN
        end else if (start_mul) begin
            cnt <= CNT_W'(WIDTH);
`endif
        end else if ((state == SHIFT) || (state == MUL)) begin
            shreg <= sh_next;
            cnt   <= cnt - CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc <= '0;
            mul_mc  <= '0;
            mul_mp  <= '0;
        end else if (start_mul) begin
            mul_acc <= '0;
            mul_mc  <= {{WIDTH{1'b0}}, a};
            mul_mp  <= b;
        end else if (state == MUL) begin
            mul_acc <= mul_acc_next;
            mul_mc  <= mul_mc << 1;
            mul_mp  <= mul_mp >> 1;
        end
    end
`endif

    assign result   = result_q;
    assign cout     = flags_q.cout;
    assign overflow = flags_q.overflow;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign less     = flags_q.less;
    assign illegal  = illegal_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit ripple ALU.
- Width is set by parameter. All results and flags are registered.
- Single-cycle logic and add/sub ops, plus multi-cycle shifts (one bit per cycle). Multiply is an optional build feature.
- Sits between the register file read stage and writeback. Valid/ready on both sides lets the sequencer stall on multi-cycle ops.

Parameters:
- WIDTH, 16: data width in bits, minimum 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width, taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts on in_valid&&in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shifts, the shift amount is b[SHAMT_W-1:0]
- op  in  3  operation select
- sub  in  1  ADD→SUB; for SRx, selects arithmetic shift
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes on out_valid&&out_ready
- result  out  WIDTH  registered result
- cout  out  1  carry-out (add/sub) or last bit shifted out (shifts)
- overflow  out  1  signed overflow (add/sub only)
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- less  out  1  signed a<b; only when op=ADD and sub=1, else 0
- illegal  out  1  op not supported in this build

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, result=0, all flags=0, in_ready=0 while rst is asserted.
- Op codes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 ADD/SUB: a+b, or a+~b+1 when sub=1.
  - 101 SLL.
  - 110 SRL (sub=0) / SRA (sub=1).
  - 111 MUL (optional feature).
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accepting a new op while the old result drains in the same cycle is legal.
- FSM states: IDLE, SHIFT, MUL, HOLD.
  - IDLE, accept logic or ADD op: result and flags are registered at the next edge; out_valid=1; state stays IDLE. Latency 1 cycle.
  - IDLE, accept shift with amount 0: behaves as a 1-cycle op; result=a, cout=0.
  - IDLE, accept shift with amount N>0: load shreg=a, cnt=N, go to SHIFT.
  - SHIFT: each cycle shifts one bit (SRA replicates the MSB), latches the shifted-out bit into cout, and decrements cnt. When cnt reaches 0, load result, set out_valid, and go to IDLE. Latency N+1 cycles.
  - HOLD: entered if a multi-cycle op finishes while out_valid=1 && !out_ready. The new result is held internally until the old one drains, then presented.
- Arithmetic rules:
  - overflow = carry into MSB XOR carry out of MSB.
  - less = result[MSB] ^ overflow.
  - cout, overflow and less are 0 for logic ops. overflow and less are 0 for shifts.
- out_valid falls after out_ready is sampled high, unless a new result lands on the same edge.
- Output hold: result and flags stay stable while out_valid && !out_ready.
- in_valid during SHIFT/MUL is ignored (in_ready=0). Operands are captured only on acceptance.
- Reset mid-operation aborts the op. No result is produced.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 111 is an unsigned shift-add multiply returning the low WIDTH bits.
  - Takes WIDTH cycles in state MUL, so latency is WIDTH+1.
  - cout = OR of the discarded high product bits (product overflow indicator). Other flags follow the result.
- Undefined: op 111 completes in 1 cycle with result=0, zero=1, illegal=1.
- illegal is 0 for all other ops in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - op localparams ALU_OP_AND…ALU_OP_MUL;
  - state typedef alu_state_t (IDLE, SHIFT, MUL, HOLD);
  - a flags struct {cout, overflow, zero, negative, less}.
- Sub-module alu_seq_comb: the purely combinational WIDTH-bit logic/add-sub datapath producing result and flags for single-cycle ops. The top holds the FSM, shift/multiply registers and output buffer.

Test Plan (WIDTH=16):
- ADD, sub=1, a=0x0005, b=0x0007, out_ready=1 → one cycle later: result=0xFFFE, negative=1, less=1, cout=0, overflow=0.
- ADD, sub=0, a=0x7FFF, b=0x0001 → result=0x8000, overflow=1, negative=1, cout=0.
- SRA, a=0x8010, b=4 → in_ready low for 4 cycles; out_valid on the 5th cycle with result=0xF801, cout=0. Then SLL with a=0x8001, b=1 → result=0x0002, cout=1.
- Backpressure: out_ready=0 and AND a=0xF0F0, b=0x0FF0 → result=0x00F0 held stable. A second op is blocked (in_ready=0) until out_ready=1, then accepted the same cycle.
- Assert rst mid-SHIFT (a=0x0001, b=10, rst at cycle 3) → immediately out_valid=0, result=0. in_ready=1 on the first cycle after rst falls.
- MUL a=0x0102, b=0x0100: with ALU_SEQ_MUL_EN → after 17 cycles result=0x0200, cout=1. Without the macro → result=0, zero=1, illegal=1 after 1 cycle.
